// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: state encoding, shift codes and op codes for the accumulator sequencer
package acc_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_M_CLR,
        S_M_ADD,
        S_M_SHR,
        S_D_SHL,
        S_D_TRY,
        S_D_FIN,
        S_DZ,
        S_DONE
    } state_t;

    localparam logic [1:0] SH_HOLD  = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;
    localparam logic [1:0] SH_LOAD  = 2'b11;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/acc_seq.sv
// acc_seq: sequencer driving the AH/AL accumulator pair for shift-add multiply and restoring divide
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int N_BITS = 4,
    parameter int CNT_W  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       op,
    input  logic       b_zero,
    input  logic       al_lsb,
    input  logic       ah_msb,
    input  logic       alu_cout,
    output logic       acc_en,
    output logic [1:0] acc_hs,
    output logic [1:0] acc_ls,
    output logic       acc_ah_reset,
    output logic       acc_carry,
    output logic       alu_sub,
    output logic       busy,
    output logic       done,
    output logic       dz_err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cflag_q, cflag_d;
    logic               q_q, q_d;
    logic               ovf_q, ovf_d;
    logic               dz_q, dz_d;
    logic               last;

    assign last = (cnt_q == CNT_W'(N_BITS - 1));

    // State register plus iteration counter and flags
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cflag_q <= 1'b0;
            q_q     <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cflag_q <= cflag_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Next state, counter advance and flag capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cflag_d = cflag_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    cflag_d = 1'b0;
                    q_d     = 1'b0;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = (op == OP_MUL) ? S_M_CLR : (b_zero ? S_DZ : S_D_SHL);
                end
            end
            S_M_CLR: state_d = S_M_ADD;
            S_M_ADD: begin
                cflag_d = al_lsb & alu_cout;
                state_d = S_M_SHR;
            end
            S_M_SHR: begin
                state_d = last ? S_DONE : S_M_ADD;
                cnt_d   = last ? cnt_q : cnt_q + CNT_W'(1);
            end
            S_D_SHL: begin
                ovf_d   = ah_msb;
                state_d = S_D_TRY;
            end
            S_D_TRY: begin
                q_d     = ovf_q | alu_cout;
                state_d = last ? S_D_FIN : S_D_SHL;
                cnt_d   = last ? cnt_q : cnt_q + CNT_W'(1);
            end
            S_D_FIN: state_d = S_DONE;
            S_DZ: begin
                dz_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator and ALU controls decoded from state and datapath feedback
    always_comb begin
        acc_en       = 1'b0;
        acc_hs       = SH_HOLD;
        acc_ls       = SH_HOLD;
        acc_ah_reset = 1'b0;
        acc_carry    = 1'b0;
        alu_sub      = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_DONE);
        done         = (state_q == S_DONE);
        dz_err       = dz_q;
        case (state_q)
            S_M_CLR: acc_ah_reset = 1'b1;
            S_M_ADD: begin
                acc_en = 1'b1;
                acc_hs = al_lsb ? SH_LOAD : SH_HOLD;
            end
            S_M_SHR: begin
                acc_en    = 1'b1;
                acc_hs    = SH_RIGHT;
                acc_ls    = SH_RIGHT;
                acc_carry = cflag_q;
            end
            S_D_SHL: begin
                acc_en    = 1'b1;
                acc_hs    = SH_LEFT;
                acc_ls    = SH_LEFT;
                acc_carry = q_q;
            end
            S_D_TRY: begin
                acc_en  = 1'b1;
                alu_sub = 1'b1;
                acc_hs  = (ovf_q | alu_cout) ? SH_LOAD : SH_HOLD;
            end
            S_D_FIN: begin
                acc_ls    = SH_LEFT;
                acc_carry = q_q;
            end
            default: ;
        endcase
    end

endmodule
